// File: rtl/sdr_port_arbiter.sv
// Arbitrates refresh, write-burst and read-burst requests onto one SDRAM controller
// command port, then paces the data strobes for the granted burst.
`ifndef DSIZE
`define DSIZE 32
`endif

module sdr_port_arbiter #(
    parameter int ASIZE     = 23,
    parameter int BURST_LEN = 8,
    parameter int CAS_LAT   = 3
) (
    input  logic                 CLK,
    input  logic                 RESET_N,
    input  logic                 REF_REQ,
    output logic                 REF_ACK,
    input  logic                 WR_REQ,
    input  logic [ASIZE-1:0]     WR_ADDR,
    output logic                 WR_GNT,
    input  logic                 RD_REQ,
    input  logic [ASIZE-1:0]     RD_ADDR,
    output logic                 RD_VALID,
    output logic [2:0]           CMD,
    output logic [ASIZE-1:0]     SADDR,
    input  logic                 CMDACK,
    output logic [`DSIZE/8-1:0]  DM
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_CMD_REF = 3'd1;
    localparam logic [2:0] S_CMD_WR  = 3'd2;
    localparam logic [2:0] S_WR_DATA = 3'd3;
    localparam logic [2:0] S_CMD_RD  = 3'd4;
    localparam logic [2:0] S_RD_WAIT = 3'd5;
    localparam logic [2:0] S_RD_DATA = 3'd6;

    localparam logic [2:0] C_NOP     = 3'b000;
    localparam logic [2:0] C_READA   = 3'b001;
    localparam logic [2:0] C_WRITEA  = 3'b010;
    localparam logic [2:0] C_REFRESH = 3'b011;

    localparam logic [7:0] LAST_WORD = 8'(BURST_LEN - 1);
    localparam logic [7:0] LAST_WAIT = (CAS_LAT >= 2) ? 8'(CAS_LAT - 2) : 8'd0;

    logic [2:0] state;
    logic [7:0] cnt;
    logic       last_rd;   // last_served: 0 = write, 1 = read
    logic       armed;     // holds off the first command until the second edge out of reset

    // NOTE: all state and outputs here use non-blocking assignments so every
    // register samples pre-edge values; blocking would create order-dependent races.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state    <= S_IDLE;
            cnt      <= 8'd0;
            last_rd  <= 1'b0;
            armed    <= 1'b0;
            CMD      <= C_NOP;
            SADDR    <= '0;
            WR_GNT   <= 1'b0;
            RD_VALID <= 1'b0;
            REF_ACK  <= 1'b0;
            DM       <= '1;
        end else begin
            armed   <= 1'b1;
            REF_ACK <= 1'b0;
            case (state)
                S_IDLE: begin
                    // Skip the REF_ACK cycle: the refresh requester only drops its level after seeing it.
                    if (armed && !REF_ACK) begin
                        if (REF_REQ) begin
                            state <= S_CMD_REF;
                            CMD   <= C_REFRESH;
                        end else if (WR_REQ && (!RD_REQ || last_rd)) begin
                            state   <= S_CMD_WR;
                            CMD     <= C_WRITEA;
                            SADDR   <= WR_ADDR;
                            last_rd <= 1'b0;
                        end else if (RD_REQ) begin
                            state   <= S_CMD_RD;
                            CMD     <= C_READA;
                            SADDR   <= RD_ADDR;
                            last_rd <= 1'b1;
                        end
                    end
                end
                S_CMD_REF: begin
                    if (CMDACK) begin
                        CMD     <= C_NOP;
                        REF_ACK <= 1'b1;
                        state   <= S_IDLE;
                    end
                end
                S_CMD_WR: begin
                    if (CMDACK) begin
                        CMD    <= C_NOP;
                        WR_GNT <= 1'b1;
                        DM     <= '0;
                        cnt    <= 8'd0;
                        state  <= S_WR_DATA;
                    end
                end
                S_WR_DATA: begin
                    if (cnt == LAST_WORD) begin
                        WR_GNT <= 1'b0;
                        DM     <= '1;
                        cnt    <= 8'd0;
                        state  <= S_IDLE;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                S_CMD_RD: begin
                    if (CMDACK) begin
                        CMD <= C_NOP;
                        cnt <= 8'd0;
                        if (CAS_LAT <= 1) begin
                            RD_VALID <= 1'b1;
                            state    <= S_RD_DATA;
                        end else begin
                            state <= S_RD_WAIT;
                        end
                    end
                end
                S_RD_WAIT: begin
                    if (cnt == LAST_WAIT) begin
                        cnt      <= 8'd0;
                        RD_VALID <= 1'b1;
                        state    <= S_RD_DATA;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                S_RD_DATA: begin
                    if (cnt == LAST_WORD) begin
                        RD_VALID <= 1'b0;
                        cnt      <= 8'd0;
                        state    <= S_IDLE;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    cnt      <= 8'd0;
                    CMD      <= C_NOP;
                    WR_GNT   <= 1'b0;
                    RD_VALID <= 1'b0;
                    DM       <= '1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sdr_port_arbiter.sv
// Directed bench for sdr_port_arbiter: reset, write/read bursts, round-robin,
// refresh deferred behind a burst, and reset during a read burst.
`ifndef DSIZE
`define DSIZE 32
`endif

module tb_sdr_port_arbiter;

    localparam int ASIZE = 23;

    logic                CLK = 1'b0;
    logic                RESET_N = 1'b1;
    logic                REF_REQ = 1'b0;
    logic                REF_ACK;
    logic                WR_REQ = 1'b0;
    logic [ASIZE-1:0]    WR_ADDR = '0;
    logic                WR_GNT;
    logic                RD_REQ = 1'b0;
    logic [ASIZE-1:0]    RD_ADDR = '0;
    logic                RD_VALID;
    logic [2:0]          CMD;
    logic [ASIZE-1:0]    SADDR;
    logic                CMDACK = 1'b0;
    logic [`DSIZE/8-1:0] DM;

    logic [`DSIZE/8-1:0] dm_ones;
    int total = 0;
    int bad   = 0;

    sdr_port_arbiter #(.ASIZE(ASIZE), .BURST_LEN(8), .CAS_LAT(3)) dut (
        .CLK(CLK), .RESET_N(RESET_N),
        .REF_REQ(REF_REQ), .REF_ACK(REF_ACK),
        .WR_REQ(WR_REQ), .WR_ADDR(WR_ADDR), .WR_GNT(WR_GNT),
        .RD_REQ(RD_REQ), .RD_ADDR(RD_ADDR), .RD_VALID(RD_VALID),
        .CMD(CMD), .SADDR(SADDR), .CMDACK(CMDACK), .DM(DM)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Waits (bounded) for the next non-NOP command; n is the number of edges waited.
    task automatic wait_cmd(output logic [2:0] c, output int n);
        c = 3'b000;
        n = 0;
        while (n < 20) begin
            tick();
            n++;
            if (CMD != 3'b000) begin
                c = CMD;
                break;
            end
        end
    endtask

    // Acks the pending command, then measures strobe latency (from the CMDACK cycle)
    // and length; raises REF_REQ during word ref_word when non-zero.
    task automatic run_burst(input string tag, input bit is_rd, input int exp_first, input int ref_word);
        int first = -1;
        int cnt = 0;
        int overlap = 0;
        int dm_bad = 0;
        logic strobe;
        CMDACK = 1'b1;
        tick();
        CMDACK = 1'b0;
        for (int k = 1; k < 40; k++) begin
            strobe = is_rd ? RD_VALID : WR_GNT;
            if ((is_rd ? WR_GNT : RD_VALID) || REF_ACK || CMD != 3'b000) overlap++;
            if (!is_rd && strobe && DM != '0) dm_bad++;
            if ((is_rd || !strobe) && DM != dm_ones) dm_bad++;
            if (strobe) begin
                if (first < 0) first = k;
                cnt++;
                if (cnt == ref_word) REF_REQ = 1'b1;
            end else if (first >= 0) begin
                break;
            end
            tick();
        end
        check({tag, "_first"}, first, exp_first);
        check({tag, "_len"}, cnt, 8);
        check({tag, "_overlap"}, overlap, 0);
        check({tag, "_dm"}, dm_bad, 0);
    endtask

    initial begin
        logic [2:0] c;
        int n;
        dm_ones = '1;

        #2 RESET_N = 1'b0;
        repeat (3) tick();
        check("rst_cmd", CMD, 3'b000);
        check("rst_saddr", SADDR, 0);
        check("rst_strobes", {WR_GNT, RD_VALID, REF_ACK}, 3'b000);
        check("rst_dm", DM, dm_ones);

        // Single write burst, CMDACK after the command has been up for three cycles.
        WR_REQ = 1'b1;
        WR_ADDR = 23'h000100;
        RESET_N = 1'b1;
        tick();
        check("wr_first_edge_nop", CMD, 3'b000);
        tick();
        check("wr_cmd0", CMD, 3'b010);
        check("wr_saddr", SADDR, 23'h000100);
        WR_REQ = 1'b0;
        WR_ADDR = 23'h000555;
        tick();
        check("wr_cmd1", CMD, 3'b010);
        tick();
        check("wr_cmd2", CMD, 3'b010);
        check("wr_saddr_held", SADDR, 23'h000100);
        run_burst("wr", 1'b0, 1, 0);
        check("wr_end_dm", DM, dm_ones);
        check("wr_end_gnt", WR_GNT, 1'b0);

        // Single read burst at the top of the address range.
        RD_REQ = 1'b1;
        RD_ADDR = 23'h7FFFF8;
        wait_cmd(c, n);
        check("rd_cmd", c, 3'b001);
        check("rd_saddr", SADDR, 23'h7FFFF8);
        RD_REQ = 1'b0;
        run_burst("rd", 1'b1, 3, 0);

        // A stray CMDACK while idle must not produce anything.
        CMDACK = 1'b1;
        tick();
        CMDACK = 1'b0;
        tick();
        check("stray_ack", {CMD, WR_GNT, RD_VALID, REF_ACK}, 6'b0);

        // Round-robin with both ports held high straight out of reset.
        RESET_N = 1'b0;
        tick();
        WR_REQ = 1'b1;
        WR_ADDR = 23'h000100;
        RD_REQ = 1'b1;
        RD_ADDR = 23'h000200;
        RESET_N = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_cmd(c, n);
            check($sformatf("rr_cmd%0d", i), c, (i % 2 == 0) ? 3'b001 : 3'b010);
            if (i > 0) check($sformatf("rr_gap%0d", i), n, 1);
            run_burst($sformatf("rr%0d", i), (i % 2 == 0), (i % 2 == 0) ? 3 : 1, 0);
        end
        WR_REQ = 1'b0;
        RD_REQ = 1'b0;

        // Refresh raised during write word 4, with a read also pending.
        WR_REQ = 1'b1;
        wait_cmd(c, n);
        check("ref_wr_cmd", c, 3'b010);
        WR_REQ = 1'b0;
        RD_REQ = 1'b1;
        run_burst("ref_wr", 1'b0, 1, 4);
        wait_cmd(c, n);
        check("ref_cmd", c, 3'b011);
        check("ref_ack_early", REF_ACK, 1'b0);
        CMDACK = 1'b1;
        tick();
        CMDACK = 1'b0;
        check("ref_ack", REF_ACK, 1'b1);
        check("ref_ack_cmd", CMD, 3'b000);
        REF_REQ = 1'b0;
        tick();
        check("ref_ack_one", REF_ACK, 1'b0);
        wait_cmd(c, n);
        check("ref_then_rd", c, 3'b001);
        check("ref_then_rd_addr", SADDR, 23'h000200);

        // Reset during read word 2.
        CMDACK = 1'b1;
        tick();
        CMDACK = 1'b0;
        tick();
        tick();
        check("rrst_word1", RD_VALID, 1'b1);
        tick();
        check("rrst_word2", RD_VALID, 1'b1);
        RESET_N = 1'b0;
        #1;
        check("rrst_valid", RD_VALID, 1'b0);
        check("rrst_cmd", CMD, 3'b000);
        check("rrst_dm", DM, dm_ones);
        tick();
        tick();
        RESET_N = 1'b1;
        tick();
        check("rrst_no_residue", {CMD, WR_GNT, RD_VALID, REF_ACK}, 6'b0);
        wait_cmd(c, n);
        check("rrst_regrant", c, 3'b001);
        check("rrst_addr", SADDR, 23'h000200);
        RD_REQ = 1'b0;
        run_burst("rrst_rd", 1'b1, 3, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sdr_port_arbiter.md
SDR_PORT_ARBITER -- requirements
Module: sdr_port_arbiter

Interface
REQ-001 Parameter ASIZE, default 23, SDRAM address width.
REQ-002 Parameter BURST_LEN, default 8, words per burst (range 1..255).
REQ-003 Parameter CAS_LAT, default 3, cycles from read CMDACK to first read word.
REQ-004 Data width is `DSIZE from Sdram_Params.v; mask width is `DSIZE/8.
REQ-005 CLK  in  1  system clock; all logic on rising edge.
REQ-006 RESET_N  in  1  asynchronous, active-low reset.
REQ-007 REF_REQ  in  1  refresh request level, held until REF_ACK.
REQ-008 REF_ACK  out  1  one-cycle refresh-accepted pulse.
REQ-009 WR_REQ  in  1  write-burst request from frame-write port.
REQ-010 WR_ADDR  in  ASIZE  write burst start address.
REQ-011 WR_GNT  out  1  write data strobe; requester presents one word per high cycle.
REQ-012 RD_REQ  in  1  read-burst request from display-read port.
REQ-013 RD_ADDR  in  ASIZE  read burst start address.
REQ-014 RD_VALID  out  1  read data valid strobe to requester.
REQ-015 CMD  out  3  controller command: 000 NOP, 001 READA, 010 WRITEA, 011 REFRESH.
REQ-016 SADDR  out  ASIZE  command address to controller.
REQ-017 CMDACK  in  1  controller command-accepted pulse.
REQ-018 DM  out  `DSIZE/8  byte mask to data path; all ones except write data cycles.

Function
REQ-019 States: IDLE, CMD_REF, CMD_WR, WR_DATA, CMD_RD, RD_WAIT, RD_DATA; all outputs registered.
REQ-020 Requests sampled only in IDLE; priority REF_REQ > round-robin(WR_REQ, RD_REQ).
REQ-021 Round-robin: both requesting -> grant the port not served last; last_served resets to write (read wins first tie).
REQ-022 Single requester granted regardless of last_served; last_served updates on every WR/RD grant.
REQ-023 On grant, selected address captured into SADDR; SADDR held stable until CMDACK; requester address changes afterwards ignored.
REQ-024 CMD_*: CMD driven with matching code every cycle until CMDACK sampled high; CMD = NOP from next cycle.
REQ-025 CMD_REF: CMDACK -> REF_ACK high exactly one cycle (next cycle), state -> IDLE.
REQ-026 CMD_WR: CMDACK -> WR_DATA; WR_GNT high and DM = 0 for exactly BURST_LEN consecutive cycles starting cycle after CMDACK.
REQ-027 CMD_RD: CMDACK -> RD_WAIT for CAS_LAT-1 cycles -> RD_DATA; RD_VALID high exactly BURST_LEN consecutive cycles, first at CAS_LAT cycles after CMDACK cycle.
REQ-028 Burst counter 8 bits, counts 0..BURST_LEN-1, no wrap beyond; exit to IDLE after last word.
REQ-029 IDLE held at least one cycle between consecutive commands (bus turnaround); no command issued in the exit cycle.
REQ-030 REF_REQ arriving during a burst waits; burst never aborted; refresh served at next IDLE ahead of pending ports.
REQ-031 CMDACK outside CMD_* states ignored.
REQ-032 WR_GNT, RD_VALID, REF_ACK mutually exclusive; never two high in one cycle.

Reset
REQ-033 RESET_N low: state IDLE, CMD = 000, SADDR = 0, WR_GNT = 0, RD_VALID = 0, REF_ACK = 0, DM = all ones, counter = 0, last_served = write.
REQ-034 Reset asserted mid-burst aborts immediately to reset values; no residual strobes after release.
REQ-035 First command after reset release issued no earlier than second rising edge with RESET_N high.

Verification
REQ-036 WR_REQ=1, WR_ADDR=0x000100, CMDACK after 2 cycles -> CMD=010 for 3 cycles, SADDR=0x000100, then 8 WR_GNT cycles with DM=0, DM=all ones after.
REQ-037 RD_REQ=1, RD_ADDR=0x7FFFF8, CMDACK -> CMD=001, RD_VALID first high 3 cycles after CMDACK, high 8 cycles.
REQ-038 WR_REQ and RD_REQ both held high after reset -> grant order RD, WR, RD, WR; one IDLE cycle between bursts.
REQ-039 REF_REQ raised during write word 4 -> write completes 8 words, next command CMD=011, REF_ACK one cycle after its CMDACK, before pending RD.
REQ-040 RESET_N low during read word 2 -> RD_VALID=0, CMD=000, DM=all ones same cycle; after release, RD_REQ re-grants cleanly.
